aes_key_schedule: RTL and testbench

//  AES-128 round-key generator, directly upstream of addRoundKey: supplies its 128-bit key operand.

---
 rtl/aes_pkg.sv | 51 +++++
 rtl/aes_sbox.sv | 11 +
 rtl/aes_key_schedule.sv | 165 ++++++++++++++++
 tb/tb_aes_key_schedule.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES package: round count, state/key types, round-constant table and
// forward S-box table. The key-schedule and the SubBytes stage both use it.
package aes_pkg;

  localparam int AES_NR = 10;

  typedef logic [127:0] aes_block_t;

  typedef enum logic {
    KS_IDLE   = 1'b0,
    KS_STREAM = 1'b1
  } ks_state_e;

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox_lookup(input logic [7:0] x);
    logic [10:0] hi;
    hi = 11'd2047 - {x, 3'b000};
    return SBOX_TABLE[hi -: 8];
  endfunction

  // Round constant for rounds 1..10; anything else yields zero.
  function automatic logic [7:0] rcon(input logic [3:0] round);
    logic [7:0] r;
    case (round)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational 8-bit AES forward S-box (shared with the SubBytes stage).
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] sbox_i,
  output logic [7:0] sbox_o
);

  assign sbox_o = sbox_lookup(sbox_i);

endmodule

// File: rtl/aes_key_schedule.sv
// AES-128 on-the-fly round-key generator. Accepts a cipher key and streams
// round keys 0..NR over a valid/ready handshake, one key per accepted cycle.
// Optional build macro AES_KS_CACHE_EN adds an 11-entry key cache and a
// replay input that re-streams the last completed expansion without S-boxes.
module aes_key_schedule
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef AES_KS_CACHE_EN
  input  logic         replay,
`endif
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key_in,
  input  logic         rk_ready,
  output logic         rk_valid,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_idx,
  output logic         done
);

  localparam logic [3:0] LAST_IDX = 4'(NR);

  ks_state_e  state_q, state_d;
  aes_block_t rk_q, rk_d;
  logic [3:0] idx_q, idx_d, idx_nxt_s;
  logic       done_q, done_d;

  logic [31:0] w0_s, w1_s, w2_s, w3_s;
  logic [31:0] rot_s, sub_s, t_s;
  logic [31:0] n0_s, n1_s, n2_s, n3_s;
  aes_block_t  calc_key_s, next_key_s;

  assign idx_nxt_s = idx_q + 4'd1;
  assign {w0_s, w1_s, w2_s, w3_s} = rk_q;

`ifdef AES_KS_CACHE_EN
  aes_block_t cache_q [0:10];
  logic       cache_ok_q, cache_ok_d;
  logic       replay_q, replay_d;
  logic       cache_we_s;

  // S-box inputs are parked at zero during replay so they do not toggle.
  assign rot_s      = replay_q ? 32'h0 : {w3_s[23:0], w3_s[31:24]};
  assign cache_we_s = (state_q == KS_STREAM) && !replay_q;
  assign next_key_s = replay_q ? cache_q[idx_nxt_s] : calc_key_s;
`else
  assign rot_s      = {w3_s[23:0], w3_s[31:24]};
  assign next_key_s = calc_key_s;
`endif

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .sbox_i (rot_s[8*g +: 8]),
      .sbox_o (sub_s[8*g +: 8])
    );
  end

  assign t_s  = sub_s ^ {rcon(idx_nxt_s), 24'h000000};
  assign n0_s = w0_s ^ t_s;
  assign n1_s = w1_s ^ n0_s;
  assign n2_s = w2_s ^ n1_s;
  assign n3_s = w3_s ^ n2_s;
  assign calc_key_s = {n0_s, n1_s, n2_s, n3_s};

  // Next-state logic: key/replay acceptance in IDLE, key advance in STREAM.
  always_comb begin
    state_d = state_q;
    rk_d    = rk_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
`ifdef AES_KS_CACHE_EN
    cache_ok_d = cache_ok_q;
    replay_d   = replay_q;
`endif
    case (state_q)
      KS_IDLE: begin
`ifdef AES_KS_CACHE_EN
        if (replay && cache_ok_q) begin
          state_d  = KS_STREAM;
          rk_d     = cache_q[0];
          idx_d    = 4'd0;
          replay_d = 1'b1;
        end else
`endif
        if (key_valid) begin
          state_d = KS_STREAM;
          rk_d    = key_in;
          idx_d   = 4'd0;
`ifdef AES_KS_CACHE_EN
          replay_d   = 1'b0;
          cache_ok_d = 1'b0;
`endif
        end else begin
          state_d = KS_IDLE;
        end
      end
      KS_STREAM: begin
        if (rk_ready) begin
          if (idx_q < LAST_IDX) begin
            idx_d = idx_nxt_s;
            rk_d  = next_key_s;
          end else begin
            // Final key taken: idx stays at NR, no wrap.
            state_d = KS_IDLE;
            done_d  = 1'b1;
`ifdef AES_KS_CACHE_EN
            cache_ok_d = 1'b1;
`endif
          end
        end else begin
          state_d = KS_STREAM;
        end
      end
      default: begin
        state_d = KS_IDLE;
      end
    endcase
  end

  // State, round-key, index and done registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= KS_IDLE;
      rk_q    <= 128'h0;
      idx_q   <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rk_q    <= rk_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

`ifdef AES_KS_CACHE_EN
  // Cache validity and replay-mode flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_ok_q <= 1'b0;
      replay_q   <= 1'b0;
    end else begin
      cache_ok_q <= cache_ok_d;
      replay_q   <= replay_d;
    end
  end

  // Key cache: every computed key is stored at its round index.
  always_ff @(posedge clk) begin
    if (cache_we_s) begin
      cache_q[idx_q] <= rk_q;
    end
  end
`endif

  assign key_ready = (state_q == KS_IDLE);
  assign rk_valid  = (state_q == KS_STREAM);
  assign rk_out    = rk_q;
  assign rk_idx    = idx_q;
  assign done      = done_q;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Self-checking bench for aes_key_schedule: known-answer table, a GF(2^8)
// reference expansion, random keys/back-pressure and reset/ignore corners.
module tb_aes_key_schedule;

  logic         clk, rst_n;
  logic         key_valid, key_ready, rk_ready, rk_valid, done;
  logic [127:0] key_in, rk_out;
  logic [3:0]   rk_idx;
`ifdef AES_KS_CACHE_EN
  logic         replay;
`endif

  aes_key_schedule dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef AES_KS_CACHE_EN
    .replay    (replay),
`endif
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_in    (key_in),
    .rk_ready  (rk_ready),
    .rk_valid  (rk_valid),
    .rk_out    (rk_out),
    .rk_idx    (rk_idx),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] key;
    int           idx;
    logic [127:0] exp;
  } vec_t;

  localparam logic [127:0] SPEC_KEY = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;

  int           n_cmp = 0;
  int           n_fail = 0;
  logic [7:0]   sb [0:255];
  logic [127:0] ref_ks [0:10];
  logic [127:0] cap [0:10];
  vec_t         vecs [0:5];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    return 8'((b << k) | (b >> (8 - k)));
  endfunction

  // S-box from first principles: multiplicative inverse then affine map.
  task automatic build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (a != 0 && gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // FIPS-197 word-array expansion into ref_ks[0..10].
  task automatic expand(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] tmp;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) ref_ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Load a key (or trigger replay), then consume the stream and check it.
  task automatic run_stream(input logic [127:0] key, input bit rnd, input bit jam, input bit via_replay);
    int got = 0, first = -1, end_c = -1, dones = 0, done_c = -1;
    bit stall = 1'b0, rdy;
    logic [127:0] h_out;
    logic [3:0]   h_idx;
    expand(key);
    @(negedge clk);
    chk("key_ready_idle", key_ready, 1);
    rk_ready = 1'b1;   // no effect while rk_valid is low
    if (via_replay) begin
`ifdef AES_KS_CACHE_EN
      replay = 1'b1;
`endif
    end else begin
      key_in = key;
      key_valid = 1'b1;
    end
    @(negedge clk);
`ifdef AES_KS_CACHE_EN
    replay = 1'b0;
`endif
    if (jam) key_in = ~key;
    else key_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (done) begin
        dones++;
        done_c = c;
        chk("idx_hold_at_done", rk_idx, 10);
        chk("valid_low_at_done", rk_valid, 0);
      end
      if (rk_valid) begin
        if (first < 0) first = c;
        chk("key_ready_stream", key_ready, 0);
        if (stall) begin
          chk("hold_out", rk_out, h_out);
          chk("hold_idx", rk_idx, h_idx);
        end
        rdy = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
        if (rdy) begin
          if (got < 11) begin
            chk("rk_idx", rk_idx, got);
            chk("rk_out", rk_out, ref_ks[got]);
            cap[got] = rk_out;
          end else begin
            chk("extra_key", got, 10);
          end
          got++;
        end
        rk_ready = rdy;
        stall = !rdy;
        h_out = rk_out;
        h_idx = rk_idx;
      end else begin
        stall = 1'b0;
        rk_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b0;
        if (got >= 11) begin
          key_valid = 1'b0;
          if (end_c < 0) end_c = c + 2;
        end
      end
      if (c == end_c) break;
      @(negedge clk);
    end
    rk_ready = 1'b0;
    key_valid = 1'b0;
    chk("keys_streamed", got, 11);
    chk("done_count", dones, 1);
    if (!rnd) chk("done_latency", done_c - first, 11);
    chk("key_ready_after", key_ready, 1);
  endtask

  task automatic check_table(input logic [127:0] key);
    for (int i = 0; i < 6; i++)
      if (vecs[i].key == key) chk($sformatf("kat_idx%0d", vecs[i].idx), cap[vecs[i].idx], vecs[i].exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_key_ready"}, key_ready, 1);
    chk({tag, "_rk_valid"}, rk_valid, 0);
    chk({tag, "_rk_out"}, rk_out, 0);
    chk({tag, "_rk_idx"}, rk_idx, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  initial begin
    logic [127:0] rkey;
    vecs[0] = '{SPEC_KEY, 0, SPEC_KEY};
    vecs[1] = '{SPEC_KEY, 1, 128'ha0fafe17_88542cb1_23a33939_2a6c7605};
    vecs[2] = '{SPEC_KEY, 2, 128'hf2c295f2_7a96b943_5935807a_7359f67f};
    vecs[3] = '{SPEC_KEY, 10, 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6};
    vecs[4] = '{128'h0, 1, 128'h62636363_62636363_62636363_62636363};
    vecs[5] = '{128'h0, 10, 128'hb4ef5bcb_3e92e211_23e951cf_6f8f188e};
    build_sbox();

    rst_n = 1'b0; key_valid = 1'b0; key_in = 128'h0; rk_ready = 1'b0;
`ifdef AES_KS_CACHE_EN
    replay = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Known key, consumer always ready.
    run_stream(SPEC_KEY, 1'b0, 1'b0, 1'b0);
    check_table(SPEC_KEY);
    // Same key with random back-pressure.
    run_stream(SPEC_KEY, 1'b1, 1'b0, 1'b0);
    check_table(SPEC_KEY);
    // key_valid held with another key during the stream, then that key.
    run_stream(SPEC_KEY, 1'b0, 1'b1, 1'b0);
    run_stream(~SPEC_KEY, 1'b0, 1'b0, 1'b0);

    // Reset at idx5 aborts asynchronously.
    @(negedge clk);
    key_in = 128'hdeadbeef_01234567_89abcdef_cafef00d;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    rk_ready = 1'b1;
    for (int c = 0; c < 20 && rk_idx != 4'd5; c++) @(negedge clk);
    chk("reach_idx5", rk_idx, 5);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    rk_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_stream(128'h00112233_44556677_8899aabb_ccddeeff, 1'b0, 1'b0, 1'b0);

    // All-zero key.
    run_stream(128'h0, 1'b0, 1'b0, 1'b0);
    check_table(128'h0);

    // Random keys, random back-pressure.
    for (int k = 0; k < 4; k++) begin
      rkey = {$urandom, $urandom, $urandom, $urandom};
      run_stream(rkey, 1'b1, 1'b0, 1'b0);
    end

`ifdef AES_KS_CACHE_EN
    // Replay after a full expansion reproduces it exactly.
    run_stream(SPEC_KEY, 1'b0, 1'b0, 1'b0);
    run_stream(SPEC_KEY, 1'b0, 1'b0, 1'b1);
    check_table(SPEC_KEY);
    // Replay after reset is ignored.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    replay = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("replay_ignored_valid", rk_valid, 0);
      chk("replay_ignored_ready", key_ready, 1);
    end
    replay = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
